// File: rtl/arb_pkg.sv
// Shared constants for the two-requester round-robin arbiter.
package arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        StIdle    = IDLE,
        StGrantA  = GRANT_A,
        StGrantB  = GRANT_B,
        StIllegal = 2'd3
    } state_e;

endpackage

// File: rtl/hold_timer.sv
// Saturating grant-hold counter; flags the last permitted cycle of a grant.
module hold_timer #(
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with registered, mutually exclusive grants
// released on done, request drop or hold-time expiry.
module rr_arb2
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CW      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic last,
    output logic timeout
);

    state_e state_q;
    logic   last_q;
    logic   timeout_q;
    logic   expired;

    // Counter sits at zero through every idle cycle, so each grant starts fresh.
    hold_timer #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (~busy),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= ID_B;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_a && (!req_b || (last_q == ID_B))) begin
                        state_q <= StGrantA;
                        last_q  <= ID_A;
                    end else if (req_b) begin
                        state_q <= StGrantB;
                        last_q  <= ID_B;
                    end
                end
                StGrantA: begin
                    // A voluntary release takes priority over the forced one.
                    if (done_a || !req_a) begin
                        state_q <= StIdle;
                    end else if (expired) begin
                        state_q   <= StIdle;
                        timeout_q <= 1'b1;
                    end
                end
                StGrantB: begin
                    if (done_b || !req_b) begin
                        state_q <= StIdle;
                    end else if (expired) begin
                        state_q   <= StIdle;
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_a   = (state_q == StGrantA);
    assign gnt_b   = (state_q == StGrantB);
    assign busy    = gnt_a | gnt_b;
    assign last    = last_q;
    assign timeout = timeout_q;

endmodule
